fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

- Program sequencer for the 9-bit core.
- Owns the program counter, the start/done handshake and load stalls.
- Resolves jump and conditional-branch redirects from decode and ALU outputs.
- Sits between the instruction ROM (addressed by `pc`) and the control decoder/ALU; gates register-file and memory writes through `instr_valid`.

## Interface
Parameters:
- `PC_W`, 12: program counter / ROM address width.
- `CNT_W`, 16: committed-instruction counter width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin program; sampled only in IDLE or DONE.
- `start_addr` in PC_W: first instruction address.
- `instruction` in 9: ROM word at `pc` (combinational read); bit0 = itype, [5:1] = opcode.
- `op_en` in 1: decoder says run-type instruction.
- `branch_flag` in 1: decoder unconditional jump.
- `mem_to_reg_flag` in 1: decoder load.
- `alu_op` in 4: decoder ALU op.
- `alu_cond` in 1: ALU compare result for the current instruction.
- `target` in PC_W: redirect address from the branch lookup table.
- `pc` out PC_W: current fetch address.
- `instr_valid` out 1: current instruction commits this cycle.
- `stall` out 1: pc held this cycle.
- `done` out 1: program finished.
- `instr_count` out CNT_W: committed instructions since last start; saturating.

## Operation
- States: IDLE, RUN, LOAD_WAIT, DONE.
- Reset (any state, including mid-program):
  - State goes to IDLE.
  - `pc`=0, `instr_count`=0.
  - `instr_valid`=0, `stall`=0, `done`=0.
- IDLE/DONE, `start`=1:
  - Next state RUN.
  - `pc`←`start_addr`, `instr_count`←0.
  - `done` drops at that edge.
- `start` in RUN/LOAD_WAIT is ignored.
- Halt:
  - Condition: `instruction[0]`=0 and `instruction[5:1]`=5'b11111.
  - In RUN: next state DONE; not committed; `pc` holds.
  - In DONE: `done`=1, `pc` holds.
- Load (RUN with `op_en`=1 and `mem_to_reg_flag`=1):
  - First cycle: `stall`=1, `instr_valid`=0; next state LOAD_WAIT.
  - LOAD_WAIT: `instr_valid`=1, `stall`=0; `pc`←`pc`+1; next state RUN.
- Taken redirect: `op_en` and (`branch_flag` or (`alu_op` ∈ {0111, 1001, 1000} and `alu_cond`)).
  - On a taken redirect, `pc`←`target`.
  - Every other committed instruction (including put-type, `op_en`=0): `pc`←`pc`+1.
- `instr_valid`=1 in RUN for every non-halt, non-load instruction.
- End of ROM: a non-redirecting instruction committed at `pc`=2^PC_W−1 commits, then the state goes to DONE. `pc` never wraps.
- `instr_count`:
  - Increments on each cycle with `instr_valid`=1.
  - Holds at 2^CNT_W−1.
- `stall`, `instr_valid`: combinational from state and inputs. `done`: decoded from state.

## Timing
- Start to first fetch: 1 cycle (`pc`=`start_addr` the cycle after the `start` edge).
- Branch/jump penalty: 0 cycles; the target is fetched the next cycle.
- Load: 2 cycles. Everything else: 1 cycle.
- Halt: `done` rises 1 cycle after the halt word is presented; it is level and held until `start` or `reset`.
- Simultaneous `reset` and `start`: `reset` wins.
- Simultaneous halt decode and redirect: halt wins.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum;
  - `HALT_OPCODE` = 5'b11111;
  - the branch ALU op constants `ALU_BEQ`=4'b1001, `ALU_BLT`=4'b0111, `ALU_BGT`=4'b1000.
- The control decoder imports the same constants.
- No sub-module. The PC register, FSM and counter sit in one module; the saturating counter is a plain always_ff block.

## Test plan
- Reset, then `start`, `start_addr`=0x010, three add words:
  - `pc` = 0x010, 0x011, 0x012, 0x013 on consecutive cycles;
  - `instr_valid`=1 each cycle; `instr_count`=3.
- Jump at 0x020 (`branch_flag`=1, `target`=0x005) → `pc`=0x005 the next cycle.
- Conditional branch (`alu_op`=1001, `target`=0x040):
  - with `alu_cond`=1 → `pc`=0x040;
  - repeated with `alu_cond`=0 → `pc`=0x021.
- Load at 0x030:
  - one cycle `stall`=1, `instr_valid`=0, `pc`=0x030;
  - next cycle `instr_valid`=1, `pc`=0x030;
  - then `pc`=0x031.
- Halt word 9'b000111110 at 0x050:
  - `done`=1 the next cycle, `pc` stays 0x050;
  - `start` with `start_addr`=0 → `done`=0, `pc`=0, `instr_count`=0.
- Mid-program:
  - `reset` during LOAD_WAIT → next cycle IDLE, `pc`=0, `done`=0, `instr_valid`=0;
  - `start` during RUN → no effect on `pc`.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 9-bit core program sequencer and control decoder:
// FSM states, the halt opcode and the branch ALU op encodings.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_LOAD_WAIT = 2'd2,
    ST_DONE      = 2'd3
  } seq_state_e;

  localparam logic [4:0] HALT_OPCODE = 5'b11111;

  localparam logic [3:0] ALU_BEQ = 4'b1001;
  localparam logic [3:0] ALU_BLT = 4'b0111;
  localparam logic [3:0] ALU_BGT = 4'b1000;

  // A run-type halt has itype 0 and the all-ones opcode.
  function automatic logic is_halt(input logic [8:0] instr);
    return (instr[0] == 1'b0) && (instr[5:1] == HALT_OPCODE);
  endfunction

  function automatic logic is_cond_branch(input logic [3:0] op);
    return (op == ALU_BEQ) || (op == ALU_BLT) || (op == ALU_BGT);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the sequencer (slave) and its host/ROM/decoder side (master).
interface fetch_sequencer_if #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  start_addr;
  logic [8:0]       instruction;
  logic             op_en;
  logic             branch_flag;
  logic             mem_to_reg_flag;
  logic [3:0]       alu_op;
  logic             alu_cond;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc;
  logic             instr_valid;
  logic             stall;
  logic             done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, start_addr, instruction, op_en, branch_flag,
           mem_to_reg_flag, alu_op, alu_cond, target,
    input  pc, instr_valid, stall, done, instr_count
  );

  modport slave (
    input  start, start_addr, instruction, op_en, branch_flag,
           mem_to_reg_flag, alu_op, alu_cond, target,
    output pc, instr_valid, stall, done, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, start/done handshake, load stalls, redirects
// and a saturating committed-instruction counter.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);

  localparam logic [PC_W-1:0]  PC_LAST  = {PC_W{1'b1}};
  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  seq_state_e       state_r;
  logic [PC_W-1:0]  pc_r;
  logic [CNT_W-1:0] cnt_r;

  logic halt_s;
  logic load_s;
  logic taken_s;
  logic launch_s;
  logic instr_valid_s;
  logic stall_s;

  assign halt_s   = is_halt(bus.instruction);
  assign load_s   = bus.op_en && bus.mem_to_reg_flag;
  assign taken_s  = bus.op_en &&
                    (bus.branch_flag || (is_cond_branch(bus.alu_op) && bus.alu_cond));
  assign launch_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && bus.start;

  // Commit/stall decode; halt takes priority over load and redirect.
  always_comb begin
    instr_valid_s = 1'b0;
    stall_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (halt_s) begin
          instr_valid_s = 1'b0;
          stall_s       = 1'b0;
        end else if (load_s) begin
          instr_valid_s = 1'b0;
          stall_s       = 1'b1;
        end else begin
          instr_valid_s = 1'b1;
          stall_s       = 1'b0;
        end
      end
      ST_LOAD_WAIT: begin
        instr_valid_s = 1'b1;
        stall_s       = 1'b0;
      end
      default: begin
        instr_valid_s = 1'b0;
        stall_s       = 1'b0;
      end
    endcase
  end

  // Sequencer FSM and program counter; the last ROM word ends the program
  // instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= {PC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_r <= ST_RUN;
            pc_r    <= bus.start_addr;
          end else begin
            state_r <= state_r;
            pc_r    <= pc_r;
          end
        end
        ST_RUN: begin
          if (halt_s) begin
            state_r <= ST_DONE;
          end else if (load_s) begin
            state_r <= ST_LOAD_WAIT;
          end else if (taken_s) begin
            pc_r    <= bus.target;
          end else if (pc_r == PC_LAST) begin
            state_r <= ST_DONE;
          end else begin
            pc_r    <= pc_r + PC_ONE;
          end
        end
        ST_LOAD_WAIT: begin
          if (pc_r == PC_LAST) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
            pc_r    <= pc_r + PC_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          pc_r    <= {PC_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating committed-instruction counter, cleared on each program launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (launch_s) begin
      cnt_r <= CNT_ZERO;
    end else if (instr_valid_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.pc          = pc_r;
  assign bus.instr_valid = instr_valid_s;
  assign bus.stall       = stall_s;
  assign bus.done        = (state_r == ST_DONE);
  assign bus.instr_count = cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer with a queue-based scoreboard and
// hand-written restart, reset and end-of-ROM sequences.
module tb_fetch_sequencer;
  import seq_pkg::*;

  localparam int PC_W  = 12;
  localparam int CNT_W = 16;
  localparam logic [8:0] ADD_W  = 9'b000000001;
  localparam logic [8:0] HALT_W = 9'b000111110;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]       instruction;
    logic             op_en;
    logic             branch_flag;
    logic             mem_to_reg_flag;
    logic [3:0]       alu_op;
    logic             alu_cond;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  exp_pc;
    logic             exp_valid;
    logic             exp_stall;
    logic             exp_done;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0]  pc;
    logic             valid;
    logic             stall;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic [8:0] ins, logic oe, logic bf, logic mtr,
                              logic [3:0] op, logic cond, logic [11:0] tgt,
                              logic [11:0] pc, logic v, logic s, logic d,
                              logic [15:0] cnt);
    vec_t r;
    r.instruction = ins; r.op_en = oe; r.branch_flag = bf; r.mem_to_reg_flag = mtr;
    r.alu_op = op; r.alu_cond = cond; r.target = tgt;
    r.exp_pc = pc; r.exp_valid = v; r.exp_stall = s; r.exp_done = d; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [8:0] ins, input logic oe, input logic bf,
                            input logic mtr, input logic [3:0] op, input logic cond,
                            input logic [11:0] tgt);
    bus.instruction = ins; bus.op_en = oe; bus.branch_flag = bf;
    bus.mem_to_reg_flag = mtr; bus.alu_op = op; bus.alu_cond = cond; bus.target = tgt;
  endtask

  task automatic expect_out(input logic [11:0] pc, input logic v, input logic s,
                            input logic d, input logic [15:0] cnt);
    exp_t e;
    e.pc = pc; e.valid = v; e.stall = s; e.done = d; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // Sample on the falling edge, away from the active edge.
  task automatic compare_out(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " pc"},          32'(bus.pc),          32'(e.pc));
      check({tag, " instr_valid"}, 32'(bus.instr_valid), 32'(e.valid));
      check({tag, " stall"},       32'(bus.stall),       32'(e.stall));
      check({tag, " done"},        32'(bus.done),        32'(e.done));
      check({tag, " instr_count"}, 32'(bus.instr_count), 32'(e.cnt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            instr  oe bf mt op       cnd tgt     | pc      v  s  d  cnt
    vecs[0]  = mk(ADD_W,  1, 0, 0, 4'b0000, 0, 12'h000, 12'h010, 1, 0, 0, 16'd0);
    vecs[1]  = mk(ADD_W,  1, 0, 0, 4'b0000, 0, 12'h000, 12'h011, 1, 0, 0, 16'd1);
    vecs[2]  = mk(ADD_W,  1, 0, 0, 4'b0000, 0, 12'h000, 12'h012, 1, 0, 0, 16'd2);
    vecs[3]  = mk(ADD_W,  1, 1, 0, 4'b0000, 0, 12'h020, 12'h013, 1, 0, 0, 16'd3);
    vecs[4]  = mk(ADD_W,  1, 1, 0, 4'b0000, 0, 12'h005, 12'h020, 1, 0, 0, 16'd4);
    vecs[5]  = mk(ADD_W,  1, 0, 0, 4'b1001, 1, 12'h040, 12'h005, 1, 0, 0, 16'd5);
    vecs[6]  = mk(ADD_W,  1, 1, 0, 4'b0000, 0, 12'h020, 12'h040, 1, 0, 0, 16'd6);
    vecs[7]  = mk(ADD_W,  1, 0, 0, 4'b1001, 0, 12'h040, 12'h020, 1, 0, 0, 16'd7);
    vecs[8]  = mk(ADD_W,  0, 1, 0, 4'b1001, 1, 12'h040, 12'h021, 1, 0, 0, 16'd8);
    vecs[9]  = mk(ADD_W,  1, 0, 0, 4'b0111, 1, 12'h030, 12'h022, 1, 0, 0, 16'd9);
    vecs[10] = mk(ADD_W,  1, 0, 1, 4'b0000, 0, 12'h000, 12'h030, 0, 1, 0, 16'd10);
    vecs[11] = mk(ADD_W,  1, 0, 1, 4'b0000, 0, 12'h000, 12'h030, 1, 0, 0, 16'd10);
    vecs[12] = mk(ADD_W,  1, 0, 0, 4'b1000, 1, 12'h050, 12'h031, 1, 0, 0, 16'd11);
    vecs[13] = mk(HALT_W, 1, 1, 0, 4'b0000, 0, 12'h007, 12'h050, 0, 0, 0, 16'd12);
    vecs[14] = mk(HALT_W, 1, 1, 0, 4'b0000, 0, 12'h007, 12'h050, 0, 0, 1, 16'd12);
    vecs[15] = mk(ADD_W,  1, 1, 0, 4'b0000, 0, 12'h007, 12'h050, 0, 0, 1, 16'd12);

    reset = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = 12'h000;
    set_inputs(ADD_W, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 12'h000);
    tick();
    tick();
    expect_out(12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    compare_out("reset");
    tick();
    reset = 1'b0;

    bus.start = 1'b1;
    bus.start_addr = 12'h010;
    tick();
    bus.start = 1'b0;

    for (int i = 0; i < 16; i++) begin
      set_inputs(vecs[i].instruction, vecs[i].op_en, vecs[i].branch_flag,
                 vecs[i].mem_to_reg_flag, vecs[i].alu_op, vecs[i].alu_cond, vecs[i].target);
      expect_out(vecs[i].exp_pc, vecs[i].exp_valid, vecs[i].exp_stall,
                 vecs[i].exp_done, vecs[i].exp_cnt);
      compare_out($sformatf("vec%0d", i));
      tick();
    end

    // Restart from DONE at address 0.
    bus.start = 1'b1;
    bus.start_addr = 12'h000;
    tick();
    bus.start = 1'b0;
    set_inputs(ADD_W, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 12'h000);
    expect_out(12'h000, 1'b1, 1'b0, 1'b0, 16'd0);
    compare_out("restart");

    // Start while running is ignored.
    bus.start = 1'b1;
    bus.start_addr = 12'h100;
    tick();
    bus.start = 1'b0;
    set_inputs(ADD_W, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 12'h000);
    expect_out(12'h001, 1'b0, 1'b1, 1'b0, 16'd1);
    compare_out("start_in_run");
    tick();
    expect_out(12'h001, 1'b1, 1'b0, 1'b0, 16'd1);
    compare_out("load_wait");

    // Reset in LOAD_WAIT.
    reset = 1'b1;
    tick();
    expect_out(12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    compare_out("reset_in_load_wait");

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.start_addr = 12'h077;
    set_inputs(ADD_W, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 12'h000);
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    expect_out(12'h000, 1'b0, 1'b0, 1'b0, 16'd0);
    compare_out("reset_beats_start");

    // Last ROM word commits then ends the program without wrapping.
    bus.start = 1'b1;
    bus.start_addr = 12'hFFF;
    tick();
    bus.start = 1'b0;
    expect_out(12'hFFF, 1'b1, 1'b0, 1'b0, 16'd0);
    compare_out("rom_end_commit");
    tick();
    expect_out(12'hFFF, 1'b0, 1'b0, 1'b1, 16'd1);
    compare_out("rom_end_done");

    // A redirect at the last ROM word keeps running.
    bus.start = 1'b1;
    bus.start_addr = 12'hFFF;
    tick();
    bus.start = 1'b0;
    set_inputs(ADD_W, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 12'h004);
    expect_out(12'hFFF, 1'b1, 1'b0, 1'b0, 16'd0);
    compare_out("rom_end_jump");
    tick();
    set_inputs(ADD_W, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 12'h000);
    expect_out(12'h004, 1'b1, 1'b0, 1'b0, 16'd1);
    compare_out("rom_end_jump_target");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
